// File: rtl/jk_cmd_seq_if.sv
// Command and replay bundle for jk_cmd_seq.
//   cmd_valid/cmd_op/cmd_len/cmd_ready : command handshake ({j,k} = cmd_op, len 0 acts as 1)
//   j/k                                : registered levels toward the downstream JK flop
//   done                               : pulse on the last applied cycle of each command
//   busy                               : sequencer running or commands still queued
//   q_exp                              : expected q of the downstream flop
// Modports: master = command source / observer, slave = the sequencer.
interface jk_cmd_seq_if #(
  parameter int unsigned CntW = 8
);
  logic            cmd_valid;
  logic [1:0]      cmd_op;
  logic [CntW-1:0] cmd_len;
  logic            cmd_ready;
  logic            j;
  logic            k;
  logic            done;
  logic            busy;
  logic            q_exp;

  modport master (
    output cmd_valid, cmd_op, cmd_len,
    input  cmd_ready, j, k, done, busy, q_exp
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len,
    output cmd_ready, j, k, done, busy, q_exp
  );
endinterface

// File: rtl/jk_cmd_seq.sv
// JK command sequencer: buffers {op,len} commands in a circular FIFO and replays each
// as registered j/k levels for max(len,1) cycles, back to back without bubbles, while
// tracking the expected q of the downstream JK flop.
// Ports:
//   clk_i   : clock, all state on rising edge
//   rst_ni  : asynchronous active-low reset (clears FIFO, FSM and outputs)
//   cmd_if  : jk_cmd_seq_if.slave, command handshake plus j/k/done/busy/q_exp
// Optional (define JKSEQ_CHECK_EN):
//   q_obs_i    : observed downstream q
//   mismatch_o : sticky, set on any edge where q_obs_i != q_exp
//   err_cnt_o  : saturating count of mismatching edges
module jk_cmd_seq #(
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  jk_cmd_seq_if.slave   cmd_if
`ifdef JKSEQ_CHECK_EN
  ,
  input  logic          q_obs_i,
  output logic          mismatch_o,
  output logic [7:0]    err_cnt_o
`endif
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned OccW = $clog2(Depth + 1);

  typedef enum logic {StIdle, StRun} state_e;

  logic [CntW+1:0] mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0] count_q, count_d;
  state_e          state_q, state_d;
  logic [CntW-1:0] remain_q, remain_d;
  logic            j_q, j_d, k_q, k_d;
  logic            done_q, done_d;
  logic            q_exp_q, q_exp_d;

  logic            full, empty, ready, push, pop;
  logic [CntW+1:0] head;
  logic [CntW-1:0] head_len, load_remain;

  assign full  = (count_q == OccW'(Depth));
  assign empty = (count_q == '0);
  // Held low while in reset, so nothing is accepted until release.
  assign ready = rst_ni & ~full;
  assign push  = cmd_if.cmd_valid & ready;
  // Pop only when idle or when the running command is on its last cycle.
  assign pop   = ~empty & ((state_q == StIdle) | (remain_q == '0));

  assign head        = mem_q[rd_ptr_q];
  assign head_len    = head[CntW-1:0];
  assign load_remain = (head_len == '0) ? '0 : head_len - 1'b1;

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    j_d      = j_q;
    k_d      = k_q;
    done_d   = 1'b0;
    if ((state_q == StRun) && (remain_q != '0)) begin
      remain_d = remain_q - 1'b1;
      done_d   = (remain_q == CntW'(1));
    end else if (pop) begin
      state_d    = StRun;
      {j_d, k_d} = head[CntW+1:CntW];
      remain_d   = load_remain;
      done_d     = (load_remain == '0);
    end else begin
      state_d = StIdle;
      j_d     = 1'b0;
      k_d     = 1'b0;
    end
  end

  always_comb begin
    unique case ({j_q, k_q})
      2'b10:   q_exp_d = 1'b1;
      2'b01:   q_exp_d = 1'b0;
      2'b11:   q_exp_d = ~q_exp_q;
      default: q_exp_d = q_exp_q;
    endcase
  end

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StIdle;
      remain_q <= '0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      done_q   <= 1'b0;
      q_exp_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {cmd_if.cmd_op, cmd_if.cmd_len};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_d;
      state_q  <= state_d;
      remain_q <= remain_d;
      j_q      <= j_d;
      k_q      <= k_d;
      done_q   <= done_d;
      q_exp_q  <= q_exp_d;
    end
  end

  assign cmd_if.cmd_ready = ready;
  assign cmd_if.j         = j_q;
  assign cmd_if.k         = k_q;
  assign cmd_if.done      = done_q;
  assign cmd_if.busy      = (state_q == StRun) | ~empty;
  assign cmd_if.q_exp     = q_exp_q;

`ifdef JKSEQ_CHECK_EN
  logic       mismatch_q, mismatch_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    mismatch_d = mismatch_q;
    err_cnt_d  = err_cnt_q;
    if (q_obs_i != q_exp_q) begin
      mismatch_d = 1'b1;
      if (err_cnt_q != 8'hff) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign mismatch_o = mismatch_q;
  assign err_cnt_o  = err_cnt_q;
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Directed bench for jk_cmd_seq; inputs driven on falling edges, outputs sampled there.
module tb_jk_cmd_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  jk_cmd_seq_if #(.CntW(8)) ifc ();

`ifdef JKSEQ_CHECK_EN
  logic       obs_force = 1'b0;
  logic       q_obs;
  logic       mismatch;
  logic [7:0] err_cnt;
  // A well-behaved downstream flop tracks q_exp; forcing 0 models a stuck flop.
  assign q_obs = obs_force ? 1'b0 : ifc.q_exp;
`endif

  jk_cmd_seq #(.Depth(4), .CntW(8)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cmd_if     (ifc)
`ifdef JKSEQ_CHECK_EN
    ,
    .q_obs_i    (q_obs),
    .mismatch_o (mismatch),
    .err_cnt_o  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    int bad = 0;
    rst_n = 1'b0;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op = 2'b00;
    ifc.cmd_len = 8'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ifc.j, ifc.k, ifc.done, ifc.busy, ifc.q_exp, ifc.cmd_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: got j,k,done,busy,q_exp,ready=%b want 000000",
               {ifc.j, ifc.k, ifc.done, ifc.busy, ifc.q_exp, ifc.cmd_ready});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ifc.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got %b want 1", ifc.cmd_ready);
    end
    repeat (5) begin
      @(negedge clk);
      if ({ifc.j, ifc.k, ifc.done, ifc.busy, ifc.q_exp} !== 5'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL idle_quiet: %0d active cycles, want 0", bad);
    end
  endtask

  task automatic test_set_toggle();
    logic [1:0] ejk [8] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    logic [7:0] eq = 8'b10101110;
    logic [7:0] ed = 8'b01000100;
    logic [7:0] eb = 8'b01111111;
    @(negedge clk);
    ifc.cmd_valid = 1'b1; ifc.cmd_op = 2'b10; ifc.cmd_len = 8'd3;
    @(negedge clk);
    ifc.cmd_op = 2'b11; ifc.cmd_len = 8'd4;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({ifc.j, ifc.k, ifc.q_exp, ifc.done, ifc.busy} !== {ejk[i], eq[i], ed[i], eb[i]}) begin
        errors++;
        $display("FAIL set_toggle[%0d]: got j,k,q,done,busy=%b want %b", i + 1,
                 {ifc.j, ifc.k, ifc.q_exp, ifc.done, ifc.busy}, {ejk[i], eq[i], ed[i], eb[i]});
      end
    end
  endtask

  task automatic test_len0_hold();
    logic [1:0] ejk [4] = '{2'b01, 2'b00, 2'b00, 2'b00};
    logic [3:0] eq = 4'b0001;
    logic [3:0] ed = 4'b0101;
    logic [3:0] eb = 4'b0111;
    @(negedge clk);
    ifc.cmd_valid = 1'b1; ifc.cmd_op = 2'b01; ifc.cmd_len = 8'd0;
    @(negedge clk);
    ifc.cmd_op = 2'b00; ifc.cmd_len = 8'd2;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({ifc.j, ifc.k, ifc.q_exp, ifc.done, ifc.busy} !== {ejk[i], eq[i], ed[i], eb[i]}) begin
        errors++;
        $display("FAIL len0_hold[%0d]: got j,k,q,done,busy=%b want %b", i + 1,
                 {ifc.j, ifc.k, ifc.q_exp, ifc.done, ifc.busy}, {ejk[i], eq[i], ed[i], eb[i]});
      end
    end
  endtask

  task automatic test_len_max();
    int done_idx = 0;
    int done_cnt = 0;
    int jcnt = 0;
    @(negedge clk);
    ifc.cmd_valid = 1'b1; ifc.cmd_op = 2'b10; ifc.cmd_len = 8'd255;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    for (int s = 1; s <= 262; s++) begin
      @(negedge clk);
      if (ifc.j && !ifc.k) jcnt++;
      if (ifc.done) begin
        done_cnt++;
        done_idx = s;
      end
    end
    checks++;
    if (jcnt !== 255) begin
      errors++;
      $display("FAIL len_max_cycles: got %0d want 255", jcnt);
    end
    checks++;
    if ({done_cnt, done_idx} !== {32'd1, 32'd255}) begin
      errors++;
      $display("FAIL len_max_done: got count %0d at %0d want 1 at 255", done_cnt, done_idx);
    end
  endtask

  task automatic test_fifo_full();
    logic [1:0] ops  [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b00};
    logic [7:0] lens [5] = '{8'd50, 8'd2, 8'd1, 8'd3, 8'd1};
    int         exp_at [5] = '{50, 52, 53, 56, 57};
    int         done_at [$];
    logic [1:0] jk_at [$];
    @(negedge clk);
    ifc.cmd_valid = 1'b1; ifc.cmd_op = ops[0]; ifc.cmd_len = lens[0];
    @(negedge clk);
    ifc.cmd_op = ops[1]; ifc.cmd_len = lens[1];
    for (int s = 1; s <= 62; s++) begin
      @(negedge clk);
      if (ifc.done) begin
        done_at.push_back(s);
        jk_at.push_back({ifc.j, ifc.k});
      end
      if (s <= 3) begin
        ifc.cmd_op = ops[s + 1]; ifc.cmd_len = lens[s + 1];
      end else if (s == 4) begin
        ifc.cmd_op = 2'b11; ifc.cmd_len = 8'd5;
      end else if (s == 8) begin
        ifc.cmd_valid = 1'b0;
      end
      if ((s >= 4 && s <= 7) || s == 50) begin
        checks++;
        if (ifc.cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL full_ready[%0d]: got %b want 0", s, ifc.cmd_ready);
        end
      end
      if (s == 51 || s == 58) begin
        checks++;
        if ({ifc.cmd_ready, ifc.busy} !== {1'b1, (s == 51)}) begin
          errors++;
          $display("FAIL full_drain[%0d]: got ready,busy=%b want %b", s,
                   {ifc.cmd_ready, ifc.busy}, {1'b1, (s == 51)});
        end
      end
    end
    checks++;
    if (done_at.size() !== 5) begin
      errors++;
      $display("FAIL full_done_count: got %0d want 5", done_at.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if ({done_at[i], jk_at[i]} !== {exp_at[i], ops[i]}) begin
          errors++;
          $display("FAIL full_order[%0d]: got done@%0d jk=%b want done@%0d jk=%b", i,
                   done_at[i], jk_at[i], exp_at[i], ops[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int bad = 0;
    @(negedge clk);
    ifc.cmd_valid = 1'b1; ifc.cmd_op = 2'b11; ifc.cmd_len = 8'd20;
    @(negedge clk);
    ifc.cmd_op = 2'b10; ifc.cmd_len = 8'd5;
    @(negedge clk);
    ifc.cmd_op = 2'b01; ifc.cmd_len = 8'd5;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({ifc.j, ifc.k, ifc.busy} !== 3'b111) begin
      errors++;
      $display("FAIL pre_reset_run: got j,k,busy=%b want 111", {ifc.j, ifc.k, ifc.busy});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ifc.j, ifc.k, ifc.q_exp, ifc.busy, ifc.done, ifc.cmd_ready} !== 6'b0) begin
      errors++;
      $display("FAIL async_clear: got j,k,q,busy,done,ready=%b want 000000",
               {ifc.j, ifc.k, ifc.q_exp, ifc.busy, ifc.done, ifc.cmd_ready});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (ifc.j || ifc.k || ifc.busy || ifc.done || !ifc.cmd_ready) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL queue_flushed: %0d bad cycles after release, want 0", bad);
    end
  endtask

`ifdef JKSEQ_CHECK_EN
  task automatic test_check();
    checks++;
    if ({mismatch, err_cnt} !== 9'b0) begin
      errors++;
      $display("FAIL chk_initial: got mismatch=%b err=%0d want 0,0", mismatch, err_cnt);
    end
    @(negedge clk);
    ifc.cmd_valid = 1'b1; ifc.cmd_op = 2'b10; ifc.cmd_len = 8'd3;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mismatch, err_cnt, ifc.q_exp} !== {1'b0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL chk_before: got mismatch=%b err=%0d q=%b want 0,0,1",
               mismatch, err_cnt, ifc.q_exp);
    end
    obs_force = 1'b1;
    @(negedge clk);
    checks++;
    if ({mismatch, err_cnt} !== {1'b1, 8'd1}) begin
      errors++;
      $display("FAIL chk_first: got mismatch=%b err=%0d want 1,1", mismatch, err_cnt);
    end
    repeat (2) @(negedge clk);
    obs_force = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({mismatch, err_cnt} !== {1'b1, 8'd3}) begin
      errors++;
      $display("FAIL chk_sticky: got mismatch=%b err=%0d want 1,3", mismatch, err_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mismatch, err_cnt} !== 9'b0) begin
      errors++;
      $display("FAIL chk_reset: got mismatch=%b err=%0d want 0,0", mismatch, err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op = 2'b00;
    ifc.cmd_len = 8'd0;
    test_reset();
    test_set_toggle();
    test_len0_hold();
    test_len_max();
    test_fifo_full();
    test_async_reset();
`ifdef JKSEQ_CHECK_EN
    test_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_cmd_seq.md
Name: jk_cmd_seq

Overview:
- Upstream stimulus stage for the team's JK flip-flop.
- Accepts JK commands (op plus duration) over a valid/ready handshake and buffers them in a small FIFO.
- Replays each command as registered j/k levels for a programmed number of clock cycles.
- Keeps a cycle-accurate model of the downstream flop's q (q_exp) so benches and neighbouring logic know the expected state.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- CNT_W, 8, width of the command length field.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- cmd_valid  input  1  command offered this cycle.
- cmd_op  input  2  00 hold, 01 reset-q, 10 set-q, 11 toggle; {j,k} = cmd_op.
- cmd_len  input  CNT_W  cycles to apply op; 0 treated as 1.
- cmd_ready  output  1  FIFO can accept; 0 when full or reset asserted.
- j  output  1  registered J to downstream flop.
- k  output  1  registered K to downstream flop.
- done  output  1  one-cycle pulse on last applied cycle of each command.
- busy  output  1  RUN state or FIFO non-empty.
- q_exp  output  1  expected downstream q.

Behaviour:
- Reset (async, reset=0): FIFO empty; state IDLE; j=0, k=0, done=0, busy=0, q_exp=0, cmd_ready=0. Mid-command reset discards the running command and all queued commands immediately. After release, cmd_ready=1 combinationally.
- Handshake: push on a rising edge with cmd_valid&cmd_ready. cmd_ready = reset & !full. No push when full, even if a pop occurs that edge.
- FIFO: circular, pointers wrap at DEPTH; occupancy counter 0..DEPTH.
- States:
  - IDLE: j=k=0. If FIFO non-empty at an edge → pop head, load j/k from op, load remain = max(len,1)-1, go RUN.
  - RUN: each edge with remain>0 → remain-1, j/k held.
  - RUN, edge with remain==0: if FIFO non-empty, pop next and load it with no bubble, stay RUN; else j=k=0 and go IDLE.
- Latency: a command pushed at edge E into an empty FIFO while IDLE drives j/k from edge E+1, for max(len,1) cycles.
- done: registered; high during the cycle where remain==0 in RUN.
- q_exp: updates every edge from the current j/k:
  - 10 → 1
  - 01 → 0
  - 11 → ~q_exp
  - 00 → hold
  - It equals a downstream JK flop on the same clk and reset that resets q=0.
- Simultaneous push and pop: both occur; occupancy unchanged.
- A push into an empty FIFO at the same edge IDLE checks the FIFO is not seen until the next edge (no bypass).
- len width: remain is CNT_W bits; len=2^CNT_W-1 is the maximum, with no overflow.

Optional Feature:
- Macro: JKSEQ_CHECK_EN.
- When defined, adds:
  - Input q_obs (1 bit): the downstream flop's q.
  - Output mismatch (1 bit, sticky): set at any edge where q_obs != q_exp, cleared only by reset.
  - Output err_cnt (8 bits, saturating at 255): counts mismatching cycles.
- When undefined: those ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset and idle: reset=0 for 2 cycles, then release → j=k=0, q_exp=0, busy=0, cmd_ready=1, done never pulses.
- Set, then toggle: push {10,len=3} then {11,len=4} back-to-back → j/k=10 for 3 cycles, then 11 for 4 cycles with no gap; q_exp=1,1,1,0,1,0,1; done pulses at cycle 3 and cycle 7; then IDLE, j=k=0.
- len=0 and hold: push {01,len=0} then {00,len=2} → reset op applied exactly 1 cycle; q_exp=0 and held 2 cycles.
- FIFO full: stall downstream by pushing {10,len=50}, then 4 more commands → cmd_ready drops after the 4th queued command; a 6th cmd_valid is not accepted until the first pop; all 5 commands execute in order.
- Async reset mid-run: during {11,len=20} at cycle 7 with 2 queued, drive reset=0 between edges → j,k,q_exp,busy clear immediately with no edge needed; after release no queued command executes.
- (JKSEQ_CHECK_EN) Tie q_obs=0 while running {10,len=3} → mismatch=1 from first mismatching edge; err_cnt=3; both hold until reset.
